ppg_pipe_reg: RTL

PPG_PIPE_REG -- requirements
Module: ppg_pipe_reg

---
 rtl/ppg_pipe_reg.sv | 121 ++++++++++++
 1 files changed

// File: rtl/ppg_pipe_reg.sv
// Two-entry elastic register slice for partial-product sets: a main register feeding out_pp
// and a skid register that absorbs one extra set. All outputs come straight from flops.
module ppg_pipe_reg #(
    parameter int PP_W      = 33,
    parameter int PP_N      = 16,
    parameter bit ZERO_IDLE = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PP_N*PP_W-1:0] in_pp,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PP_N*PP_W-1:0] out_pp,
    output logic [1:0]           occ
);

    localparam int DW = PP_N * PP_W;

    // The encoding doubles as the occupancy count, so occ is a flop output.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e        state_q;
    state_e        state_d;
    logic [DW-1:0] main_q;
    logic [DW-1:0] skid_q;
    logic          in_ready_q;
    logic          out_valid_q;

    logic in_xfer;
    logic out_xfer;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid;
    logic clear_main;
    logic clear_skid;

    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid_q & out_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != TWO);
            out_valid_q <= (state_d != EMPTY);
        end
    end

    // NOTE: every combinational output gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY:   if (in_xfer) state_d = ONE;
                ONE: begin
                    if (in_xfer && !out_xfer)      state_d = TWO;
                    else if (!in_xfer && out_xfer) state_d = EMPTY;
                end
                TWO:     if (out_xfer) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        clear_main     = 1'b0;
        clear_skid     = 1'b0;
        if (flush) begin
            clear_main = ZERO_IDLE;
            clear_skid = ZERO_IDLE;
        end else begin
            case (state_q)
                EMPTY: load_main_in = in_xfer;
                ONE: begin
                    load_main_in = in_xfer & out_xfer;
                    load_skid    = in_xfer & ~out_xfer;
                    clear_main   = ZERO_IDLE & out_xfer & ~in_xfer;
                end
                TWO:     load_main_skid = out_xfer;
                default: clear_main     = 1'b0;
            endcase
        end
    end

    // NOTE: the data registers are reset too, because out_pp must read zero straight after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (clear_main)          main_q <= '0;
            else if (load_main_in)   main_q <= in_pp;
            else if (load_main_skid) main_q <= skid_q;

            if (clear_skid)          skid_q <= '0;
            else if (load_skid)      skid_q <= in_pp;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_pp    = main_q;
    assign occ       = state_q;

endmodule
